// File: rtl/reg_bank_seq.sv
// Four-entry register bank with a LOAD/MOVE/SWAP/CLEAR command sequencer (IDLE -> READ -> WRITE).
// Optional build macro REG0_HARDWIRE_EN makes register 0 a constant zero.
module reg_bank_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [1:0]       cmd_dst,
    input  logic [1:0]       cmd_src,
    input  logic [WIDTH-1:0] cmd_data,
    output logic             done,
    output logic             busy,
    input  logic [1:0]       rd_sel,
    output logic [WIDTH-1:0] rd_data,
    output logic [WIDTH-1:0] q1,
    output logic [WIDTH-1:0] q2,
    output logic [WIDTH-1:0] q3,
    output logic [WIDTH-1:0] q4
);

    typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;
    typedef enum logic [1:0] {OP_LOAD, OP_MOVE, OP_SWAP, OP_CLEAR} op_t;

    state_t           state_q, state_d;
    op_t              op_q, op_d;
    logic [1:0]       dst_q, dst_d;
    logic [1:0]       src_q, src_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] tmp_a_q, tmp_a_d;
    logic [WIDTH-1:0] tmp_b_q, tmp_b_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] regs_q [4];
    logic [WIDTH-1:0] regs_d [4];
    logic [WIDTH-1:0] view   [4];

    // Handshake: a command transfers on any rising edge where cmd_valid && cmd_ready;
    // cmd_ready is high only in IDLE, and cmd_* are ignored at every other time.
    assign cmd_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign done      = done_q;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        dst_d   = dst_q;
        src_d   = src_q;
        data_d  = data_q;
        tmp_a_d = tmp_a_q;
        tmp_b_d = tmp_b_q;
        regs_d  = regs_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    op_d    = op_t'(cmd_op);
                    dst_d   = cmd_dst;
                    src_d   = cmd_src;
                    data_d  = cmd_data;
                    state_d = READ;
                end
            end
            READ: begin
                case (op_q)
                    OP_LOAD:  tmp_a_d = data_q;
                    OP_MOVE:  tmp_a_d = regs_q[src_q];
                    OP_SWAP: begin
                        tmp_a_d = regs_q[src_q];
                        tmp_b_d = regs_q[dst_q];
                    end
                    default:  tmp_a_d = '0;
                endcase
                state_d = WRITE;
            end
            WRITE: begin
                // For SWAP with src == dst the second write restores the original value.
                regs_d[dst_q] = tmp_a_q;
                if (op_q == OP_SWAP) begin
                    regs_d[src_q] = tmp_b_q;
                end
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
`ifdef REG0_HARDWIRE_EN
        regs_d[0] = '0;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= OP_LOAD;
            dst_q   <= '0;
            src_q   <= '0;
            data_q  <= '0;
            tmp_a_q <= '0;
            tmp_b_q <= '0;
            done_q  <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            dst_q   <= dst_d;
            src_q   <= src_d;
            data_q  <= data_d;
            tmp_a_q <= tmp_a_d;
            tmp_b_q <= tmp_b_d;
            done_q  <= done_d;
            for (int i = 0; i < 4; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            view[i] = regs_q[i];
        end
`ifdef REG0_HARDWIRE_EN
        view[0] = '0;
`endif
    end

    assign rd_data = view[rd_sel];
    assign q1      = view[0];
    assign q2      = view[1];
    assign q3      = view[2];
    assign q4      = view[3];

endmodule
